// File: rtl/gpu_cmd_sequencer_if.sv
// Operation bus between the command sequencer and the GPU execution unit.
// The sequencer presents ops over a valid/ready handshake; the execution unit
// returns exactly one result pulse per accepted op, in issue order.
interface gpu_cmd_sequencer_if;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_code;
  logic [15:0] op_addr_a;
  logic [15:0] op_addr_b;
  logic [15:0] op_data;
  logic        result_valid;
  logic [15:0] result_data;

  // Sequencer side: presents ops, retires results.
  modport master (
    output op_valid, op_code, op_addr_a, op_addr_b, op_data,
    input  op_ready, result_valid, result_data
  );

  // Execution unit side: accepts ops, produces results.
  modport slave (
    input  op_valid, op_code, op_addr_a, op_addr_b, op_data,
    output op_ready, result_valid, result_data
  );
endinterface

// File: rtl/gpu_cmd_sequencer.sv
// GPU command sequencer: consumes the CPU->GPU mailbox, issues a burst of
// operations to the execution unit while stepping two PCs, and retires the
// results into gpu_data_out for the CPU to read back.
//
// Build option GPU_SEQ_RESTART_EN: when defined, a nonzero instruction write
// while busy aborts the running command and starts the new one; when not
// defined, such a write is dropped and flagged on the sticky overrun output.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a nonzero instruction write
// ISSUE | presenting ops; PCs step on every accepted op
// DRAIN | all ops issued, waiting for outstanding results
// DONE  | one-cycle completion pulse, then back to IDLE
module gpu_cmd_sequencer #(
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_write,
  input  logic [7:0]                 gpu_instr,
  input  logic [15:0]                gpu_pca,
  input  logic [15:0]                gpu_pcb,
  input  logic [7:0]                 gpu_pcai,
  input  logic [7:0]                 gpu_pcbi,
  input  logic [7:0]                 gpu_repeat,
  input  logic [15:0]                gpu_cpu_data,
  gpu_cmd_sequencer_if.master        op_bus,
  output logic [15:0]                gpu_data_out,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The outstanding counter is 4 bits wide, so the cap is limited to 1..15.
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t      state;
  logic        op_valid_q;
  logic [7:0]  op_code_q;
  logic [15:0] pca_q;
  logic [15:0] pcb_q;
  logic [7:0]  pcai_q;
  logic [7:0]  pcbi_q;
  logic [15:0] data_q;
  logic [7:0]  remaining;
  logic [3:0]  outstanding;

  logic        handshake;
  logic        retire;
  logic        new_cmd;
  logic        load_cmd;
  logic [3:0]  out_nxt;

  assign op_bus.op_valid  = op_valid_q;
  assign op_bus.op_code   = op_code_q;
  assign op_bus.op_addr_a = pca_q;
  assign op_bus.op_addr_b = pcb_q;
  assign op_bus.op_data   = data_q;

  // Handshake/retire qualification and the next outstanding count.
  // A stray result with nothing outstanding (e.g. after a reset) is dropped.
  always_comb begin
    handshake = op_valid_q && op_bus.op_ready;
    retire    = op_bus.result_valid && (outstanding != 4'd0);
    new_cmd   = instr_write && (gpu_instr != 8'd0);
`ifdef GPU_SEQ_RESTART_EN
    load_cmd  = new_cmd;
`else
    load_cmd  = new_cmd && (state == IDLE);
`endif
    out_nxt   = outstanding;
    if (handshake && !retire) begin
      out_nxt = outstanding + 4'd1;
    end else if (!handshake && retire) begin
      out_nxt = outstanding - 4'd1;
    end
  end

  // Sequencer FSM with registered op fields, status outputs and result capture.
  // op_valid is registered from the next outstanding count so that it reads
  // as "outstanding < cap" in the same cycle the count is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_valid_q   <= 1'b0;
      op_code_q    <= 8'd0;
      pca_q        <= 16'd0;
      pcb_q        <= 16'd0;
      pcai_q       <= 8'd0;
      pcbi_q       <= 8'd0;
      data_q       <= 16'd0;
      remaining    <= 8'd0;
      outstanding  <= 4'd0;
      gpu_data_out <= 16'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifndef GPU_SEQ_RESTART_EN
      overrun      <= 1'b0;
`endif
    end else begin
      outstanding <= out_nxt;
      if (retire) begin
        gpu_data_out <= op_bus.result_data;
      end

`ifndef GPU_SEQ_RESTART_EN
      if (new_cmd && (state != IDLE)) begin
        overrun <= 1'b1;
      end
`endif

      if (load_cmd) begin
        // Snapshot the mailbox; with restart enabled this also replaces a
        // running command, while its in-flight results keep retiring.
        op_code_q <= gpu_instr;
        pca_q     <= gpu_pca;
        pcb_q     <= gpu_pcb;
        pcai_q    <= gpu_pcai;
        pcbi_q    <= gpu_pcbi;
        data_q    <= gpu_cpu_data;
        remaining <= gpu_repeat;
        busy      <= 1'b1;
        if (gpu_repeat == 8'd0) begin
          state      <= DONE;
          done       <= 1'b1;
          op_valid_q <= 1'b0;
        end else begin
          state      <= ISSUE;
          done       <= 1'b0;
          op_valid_q <= (out_nxt < MAX_OUT);
        end
      end else begin
        case (state)
          IDLE: begin
            op_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
          end
          ISSUE: begin
            if (handshake) begin
              pca_q     <= pca_q + {8'd0, pcai_q};
              pcb_q     <= pcb_q + {8'd0, pcbi_q};
              remaining <= remaining - 8'd1;
            end
            if (handshake && (remaining == 8'd1)) begin
              state      <= DRAIN;
              op_valid_q <= 1'b0;
            end else begin
              op_valid_q <= (out_nxt < MAX_OUT);
            end
          end
          DRAIN: begin
            op_valid_q <= 1'b0;
            if (out_nxt == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state      <= IDLE;
            op_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            op_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef GPU_SEQ_RESTART_EN
  // Restart mode never drops a command, so there is nothing to flag.
  assign overrun = 1'b0;
`endif

endmodule

// File: doc/gpu_cmd_sequencer.md
# gpu_cmd_sequencer

GPU-side consumer of the CPU→GPU mailbox registers (instruction, PC A/B, PC increments, repeat count, CPU→GPU data). On an instruction write it snapshots the mailbox and issues `gpu_repeat` operations to the GPU execution unit over a valid/ready handshake. After each issue it steps both PCs by their increments. It retires results into the `gpu_data_out` register that the CPU reads back through the memory map. It sits between the RAM mailbox bytes and the GPU datapath.

## Interface
- `MAX_OUTSTANDING`, default 15: maximum issued-but-unretired ops (1..15).

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `instr_write` input 1: one-cycle pulse when the CPU writes mailbox 0x7FF5.
- `gpu_instr` input 8: opcode; 0 = NOP.
- `gpu_pca` input 16: PC A start value.
- `gpu_pcb` input 16: PC B start value.
- `gpu_pcai` input 8: PC A increment, unsigned.
- `gpu_pcbi` input 8: PC B increment, unsigned.
- `gpu_repeat` input 8: op count.
- `gpu_cpu_data` input 16: operand passed with every op.
- `op_valid` output 1: op presented to the execution unit.
- `op_ready` input 1: execution unit accepts the op.
- `op_code` output 8: opcode field of the presented op.
- `op_addr_a` output 16: PC A field of the presented op.
- `op_addr_b` output 16: PC B field of the presented op.
- `op_data` output 16: operand field of the presented op.
- `result_valid` input 1: one-cycle pulse, one per accepted op, in order.
- `result_data` input 16: result value.
- `gpu_data_out` output 16: last retired result, mapped at 0x7FF3/0x7FF4.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle completion pulse.
- `overrun` output 1: sticky; only present when restart is compiled out.

## Operation
- Reset:
  - All outputs are 0.
  - Outstanding count and remaining count are 0.
  - State is IDLE.
- State machine states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - An `instr_write` with `gpu_instr` ≠ 0 snapshots the opcode, PCs, increments and `gpu_cpu_data`.
  - `remaining` is loaded with `gpu_repeat`.
  - If `gpu_repeat` = 0, go to DONE directly. Otherwise go to ISSUE.
  - An `instr_write` with `gpu_instr` = 0 is ignored.
- ISSUE:
  - `op_valid` = 1 while outstanding < `MAX_OUTSTANDING`.
  - A handshake occurs when `op_valid && op_ready`. On each handshake:
    - PC A += `gpu_pcai`; PC B += `gpu_pcbi`.
    - Both PCs are 16-bit and wrap modulo 2^16.
    - Increments are zero-extended.
    - `remaining` decrements; outstanding increments.
  - The handshake that takes `remaining` from 1 to 0 moves the state to DRAIN.
  - `op_*` fields are stable while `op_valid` is high and not yet accepted.
- Results:
  - On `result_valid`, `gpu_data_out` ← `result_data` and outstanding decrements.
  - A handshake and a result in the same cycle leave outstanding unchanged.
  - `result_valid` arriving with outstanding = 0 is ignored: `gpu_data_out` is not updated.
- DRAIN: when outstanding reaches 0, go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `instr_write` while busy: behaviour is set by `GPU_SEQ_RESTART_EN` (see Configuration).

## Timing
- `instr_write` sampled at edge N → `busy` = 1 and `op_valid` = 1 from cycle N+1.
- With `op_ready` held high and no stall, throughput is one op per cycle. `gpu_repeat` = R finishes issuing at edge N+R.
- `gpu_data_out` updates at the edge that samples `result_valid`.
- `done` is asserted in the cycle after the last result is retired. `busy` falls together with `done`.
- `gpu_repeat` = 0: `done` at N+1, `busy` high for that single cycle, no ops issued.
- Reset asserted mid-operation:
  - Takes effect at the next edge and discards pending ops.
  - Results arriving after reset are ignored.
  - `done` is not pulsed.

## Configuration
- `GPU_SEQ_RESTART_EN` defined:
  - `instr_write` (nonzero opcode) while busy aborts the current command.
  - The mailbox is re-snapshotted and the state goes to ISSUE, or to DONE if the repeat count is 0.
  - Outstanding results are still retired into `gpu_data_out`.
  - No `done` is pulsed for the aborted command.
  - `overrun` is absent (tied 0).
- Not defined:
  - `instr_write` while busy is ignored and the running command completes unchanged.
  - `overrun` is set to 1 and stays 1 until reset.

## Test plan
- Basic sequence:
  - Stimulus: `gpu_pca` = 0x0100, `gpu_pcai` = 2, `gpu_pcb` = 0x0200, `gpu_pcbi` = 4, `gpu_repeat` = 3, `op_ready` = 1, results returned 2 cycles after issue.
  - Required: `op_addr_a` = 0x0100/0x0102/0x0104, `op_addr_b` = 0x0200/0x0204/0x0208, `gpu_data_out` = third result, one `done` pulse.
- PC wrap:
  - Stimulus: `gpu_pca` = 0xFFFE, `gpu_pcai` = 3, `gpu_repeat` = 2.
  - Required: `op_addr_a` = 0xFFFE then 0x0001.
- Back-pressure and cap:
  - Stimulus: `op_ready` toggled randomly; results withheld until 15 ops are outstanding.
  - Required: `op_valid` drops at outstanding = 15; `op_*` fields stable while stalled; all ops issued exactly once.
- Edge commands:
  - Stimulus: `gpu_repeat` = 0, then `gpu_instr` = 0 with `gpu_repeat` = 5.
  - Required: first gives `done` at N+1 with no `op_valid`; second gives no activity and `busy` stays 0.
- Reset mid-command:
  - Stimulus: reset during ISSUE with 3 ops outstanding.
  - Required: all outputs 0 the next cycle; late `result_valid` does not change `gpu_data_out`.
- Busy write, both builds:
  - Stimulus: `instr_write` while busy.
  - Required with `GPU_SEQ_RESTART_EN`: the new PCs appear on the next issue.
  - Required without it: the original sequence completes and `overrun` = 1.
